// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - size encodings and lane-mask helpers shared by the store and load paths
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } sz_e;

  // Byte-lane mask of an access of the given size, anchored at lane 0.
  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE:  lane_mask = 8'h01;
      SZ_HALF:  lane_mask = 8'h03;
      SZ_WORD:  lane_mask = 8'h0f;
      default:  lane_mask = 8'hff;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE:  align_mask = 3'b000;
      SZ_HALF:  align_mask = 3'b001;
      SZ_WORD:  align_mask = 3'b011;
      default:  align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/st_align.sv
// rtl/st_align.sv - store legality check and placement of store data into its word lanes
module st_align
  import dm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                st_valid,
  input  logic [1:0]          st_size,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [DATA_W-1:0]   st_data,
  output logic                exc,
  output logic [ADDR_W-1:0]   waddr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] byteen
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  logic [OFF_W-1:0]  off;
  logic [BE_W-1:0]   lanes;
  logic [DATA_W-1:0] dmask;
  logic              oversize;
  logic              misalign;

  assign off      = st_addr[OFF_W-1:0];
  assign lanes    = BE_W'(lane_mask(st_size));
  assign oversize = 32'(st_size) > OFF_W;
  assign misalign = |(st_addr[2:0] & align_mask(st_size));
  assign exc      = st_valid & (oversize | misalign);

  always_comb begin
    dmask = '0;
    for (int i = 0; i < BE_W; i++) begin
      dmask[8*i +: 8] = {8{lanes[i]}};
    end
  end

  assign waddr  = st_addr & ~ADDR_W'(BE_W - 1);
  assign byteen = lanes << off;
  assign wdata  = (st_data & dmask) << {off, 3'b000};

endmodule

// File: rtl/dm_store_queue.sv
// rtl/dm_store_queue.sv - pending-store FIFO draining to memory, with a load-overlap probe
module dm_store_queue
  import dm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    st_valid,
  input  logic [1:0]              st_size,
  input  logic [ADDR_W-1:0]       st_addr,
  input  logic [DATA_W-1:0]       st_data,
  output logic                    st_ready,
  output logic                    st_exc,
  output logic                    m_req,
  output logic [ADDR_W-1:0]       m_addr,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W/8-1:0]     m_byteen,
  input  logic                    m_ack,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [DATA_W/8-1:0]     ld_byteen,
  output logic                    ld_hit,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [BE_W-1:0]   be_q    [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;

  logic [ADDR_W-1:0] al_addr;
  logic [DATA_W-1:0] al_data;
  logic [BE_W-1:0]   al_be;
  logic [ADDR_W-1:0] ld_waddr;
  logic              enq;
  logic              deq;

  st_align #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_align (
    .st_valid (st_valid),
    .st_size  (st_size),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .exc      (st_exc),
    .waddr    (al_addr),
    .wdata    (al_data),
    .byteen   (al_be)
  );

  assign st_ready = (count != CNT_W'(DEPTH));
  assign m_req    = (count != '0);
  assign enq      = st_valid & st_ready & ~st_exc;
  assign deq      = m_req & m_ack;

  // Head fields are forced to zero when empty so stale slots never leak out.
  assign m_addr   = m_req ? addr_q[rptr] : '0;
  assign m_wdata  = m_req ? data_q[rptr] : '0;
  assign m_byteen = m_req ? be_q[rptr]   : '0;

  assign ld_waddr = ld_addr & ~ADDR_W'(BE_W - 1);

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == ld_waddr && (be_q[i] & ld_byteen) != '0) begin
        ld_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      wptr    <= '0;
      rptr    <= '0;
      valid_q <= '0;
    end else begin
      if (deq) begin
        valid_q[rptr] <= 1'b0;
        rptr          <= rptr + PTR_W'(1);
      end
      if (enq) begin
        addr_q[wptr]  <= al_addr;
        data_q[wptr]  <= al_data;
        be_q[wptr]    <= al_be;
        valid_q[wptr] <= 1'b1;
        wptr          <= wptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_store_queue.sv
// tb/tb_dm_store_queue.sv - directed bench for dm_store_queue with a queue-based reference model
module tb_dm_store_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_exc;
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic        m_ack;
  logic [31:0] ld_addr;
  logic [3:0]  ld_byteen;
  logic        ld_hit;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  bit modeling = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t mq[$];

  dm_store_queue #(.DATA_W(32), .DEPTH(4), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_size   (st_size),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .st_exc    (st_exc),
    .m_req     (m_req),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_byteen  (m_byteen),
    .m_ack     (m_ack),
    .ld_addr   (ld_addr),
    .ld_byteen (ld_byteen),
    .ld_hit    (ld_hit),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_illegal(input bit v, input logic [1:0] sz, input logic [31:0] a);
    int nbytes;
    nbytes = 1 << sz;
    return v && (nbytes > 4 || (a % nbytes) != 0);
  endfunction

  function automatic ent_t m_form(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int off;
    off = a % 4;
    e.addr = a - off;
    e.be = '0;
    e.data = '0;
    for (int b = 0; b < (1 << sz) && off + b < 4; b++) begin
      e.be[off+b] = 1'b1;
      e.data[8*(off+b) +: 8] = d[8*b +: 8];
    end
    return e;
  endfunction

  always @(posedge clk) begin
    ent_t e;
    bit   do_enq;
    bit   do_deq;
    if (reset) begin
      mq.delete();
      modeling = 1;
    end else begin
      do_enq = st_valid && !m_illegal(st_valid, st_size, st_addr) && mq.size() < 4;
      do_deq = mq.size() > 0 && m_ack;
      e = m_form(st_size, st_addr, st_data);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    bit hit;
    if (modeling) begin
      hit = 0;
      foreach (mq[i]) begin
        if (mq[i].addr == (ld_addr & 32'hffff_fffc) && (mq[i].be & ld_byteen) != 0) hit = 1;
      end
      chk("mdl_count", 64'(count), 64'(mq.size()));
      chk("mdl_st_ready", 64'(st_ready), 64'(mq.size() != 4));
      chk("mdl_m_req", 64'(m_req), 64'(mq.size() != 0));
      chk("mdl_st_exc", 64'(st_exc), 64'(m_illegal(st_valid, st_size, st_addr)));
      chk("mdl_ld_hit", 64'(ld_hit), 64'(hit));
      chk("mdl_m_addr", 64'(m_addr), mq.size() != 0 ? 64'(mq[0].addr) : 64'd0);
      chk("mdl_m_wdata", 64'(m_wdata), mq.size() != 0 ? 64'(mq[0].data) : 64'd0);
      chk("mdl_m_byteen", 64'(m_byteen), mq.size() != 0 ? 64'(mq[0].be) : 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic idle();
    st_valid = 1'b0;
    st_size  = 2'd0;
    st_addr  = '0;
    st_data  = '0;
  endtask

  task automatic ack_once();
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    m_ack = 1'b0;
    ld_addr = '0;
    ld_byteen = 4'hf;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_m_byteen", 64'(m_byteen), 64'd0);
    chk("rst_ld_hit", 64'(ld_hit), 64'd0);
    tick();

    store(2'd0, 32'h1003, 32'h0000_00ab);
    @(negedge clk);
    chk("sb_exc", 64'(st_exc), 64'd0);
    tick();
    idle();
    @(negedge clk);
    chk("sb_m_addr", 64'(m_addr), 64'h1000);
    chk("sb_m_byteen", 64'(m_byteen), 64'b1000);
    chk("sb_m_wdata", 64'(m_wdata), 64'hab00_0000);
    chk("sb_count", 64'(count), 64'd1);

    ld_addr = 32'h1000;
    ld_byteen = 4'b0001;
    @(negedge clk);
    chk("probe_lane0", 64'(ld_hit), 64'd0);
    tick();
    ld_byteen = 4'b1000;
    @(negedge clk);
    chk("probe_lane3", 64'(ld_hit), 64'd1);
    tick();
    ld_addr = 32'h1004;
    @(negedge clk);
    chk("probe_other_word", 64'(ld_hit), 64'd0);
    tick();
    ld_addr = 32'h1002;
    ack_once();
    @(negedge clk);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_ld_hit", 64'(ld_hit), 64'd0);

    store(2'd1, 32'h2002, 32'h0000_1234);
    tick();
    idle();
    @(negedge clk);
    chk("sh_m_byteen", 64'(m_byteen), 64'b1100);
    chk("sh_m_wdata", 64'(m_wdata), 64'h1234_0000);
    chk("sh_m_addr", 64'(m_addr), 64'h2000);
    ack_once();

    store(2'd1, 32'h2001, 32'h0000_5555);
    @(negedge clk);
    chk("mis_exc", 64'(st_exc), 64'd1);
    tick();
    idle();
    @(negedge clk);
    chk("mis_count", 64'(count), 64'd0);
    chk("mis_m_req", 64'(m_req), 64'd0);

    store(2'd3, 32'h3000, 32'h1111_1111);
    @(negedge clk);
    chk("dword_exc", 64'(st_exc), 64'd1);
    tick();
    idle();
    ack_once();
    @(negedge clk);
    chk("ack_empty_count", 64'(count), 64'd0);

    for (int i = 0; i < 4; i++) begin
      store(2'd2, 32'h100 + 32'(4 * i), 32'ha000_0000 + 32'(i));
      tick();
    end
    store(2'd2, 32'h110, 32'h0000_eeee);
    @(negedge clk);
    chk("full_count", 64'(count), 64'd4);
    chk("full_st_ready", 64'(st_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("full_ignore_count", 64'(count), 64'd4);
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    idle();
    @(negedge clk);
    chk("full_ack_count", 64'(count), 64'd3);
    chk("full_ack_head", 64'(m_addr), 64'h104);
    chk("full_ack_data", 64'(m_wdata), 64'ha000_0001);

    ack_once();
    @(negedge clk);
    chk("two_count", 64'(count), 64'd2);
    store(2'd2, 32'h200, 32'h0000_beef);
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    idle();
    @(negedge clk);
    chk("both_count", 64'(count), 64'd2);
    chk("both_head", 64'(m_addr), 64'h10c);
    ack_once();
    @(negedge clk);
    chk("order_head", 64'(m_addr), 64'h200);
    chk("order_data", 64'(m_wdata), 64'h0000_beef);
    ack_once();
    @(negedge clk);
    chk("order_empty", 64'(count), 64'd0);

    for (int i = 0; i < 3; i++) begin
      store(2'd2, 32'h300 + 32'(4 * i), 32'(i));
      tick();
    end
    idle();
    @(negedge clk);
    chk("pre_rst_count", 64'(count), 64'd3);
    chk("pre_rst_m_req", 64'(m_req), 64'd1);
    reset = 1'b1;
    store(2'd2, 32'h400, 32'h1);
    m_ack = 1'b1;
    tick();
    reset = 1'b0;
    m_ack = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_m_req", 64'(m_req), 64'd0);
    chk("post_rst_st_ready", 64'(st_ready), 64'd1);

    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
